// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings and op-class helpers for the HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

   typedef enum logic [2:0] {
      HILO_OP_NONE  = 3'd0,
      HILO_OP_MULT  = 3'd1,
      HILO_OP_MULTU = 3'd2,
      HILO_OP_DIV   = 3'd3,
      HILO_OP_DIVU  = 3'd4,
      HILO_OP_MTHI  = 3'd5,
      HILO_OP_MTLO  = 3'd6
   } hilo_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } hilo_state_e;

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == HILO_OP_MULT) || (op == HILO_OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on operand
// magnitudes, with sign and divide-by-zero fix-up applied on the outputs.
module hilo_muldiv_unit_div_radix2 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              signed_en,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              done
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic              busy;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] quo, rem, den, dividend_q;
   logic              q_neg, r_neg, den_zero;
   logic [DATA_W-1:0] a_mag, b_mag, diff;
   logic [DATA_W:0]   shifted;

   assign a_mag   = (signed_en && dividend[DATA_W-1]) ? -dividend : dividend;
   assign b_mag   = (signed_en && divisor[DATA_W-1])  ? -divisor  : divisor;
   assign shifted = {rem, quo[DATA_W-1]};
   // Only consumed when shifted >= den, so the result always fits DATA_W bits.
   assign diff    = shifted[DATA_W-1:0] - den;
   assign done    = busy && (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         cnt        <= '0;
         quo        <= '0;
         rem        <= '0;
         den        <= '0;
         dividend_q <= '0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         den_zero   <= 1'b0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy       <= 1'b1;
         cnt        <= CNT_W'(DATA_W);
         quo        <= a_mag;
         rem        <= '0;
         den        <= b_mag;
         dividend_q <= dividend;
         q_neg      <= signed_en && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
         r_neg      <= signed_en && dividend[DATA_W-1];
         den_zero   <= (divisor == '0);
      end else if (busy) begin
         if (shifted >= {1'b0, den}) begin
            rem <= diff;
            quo <= {quo[DATA_W-2:0], 1'b1};
         end else begin
            rem <= shifted[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b0};
         end
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) busy <= 1'b0;
      end
   end

   // MIN / -1 needs no special case: the negated magnitude wraps back to MIN.
   assign quotient  = den_zero ? '1 : (q_neg ? -quo : quo);
   assign remainder = den_zero ? dividend_q : (r_neg ? -rem : rem);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a pipelined multiplier and an iterative divider;
// stalls the pipeline while a multiply or divide result is pending.
//
// state   | meaning
// IDLE    | accepts start_i; MTHI/MTLO write here, mul/div launch here
// MUL     | product travelling down the MUL_STAGES-deep pipeline
// DIV     | divider iterating, one quotient bit per cycle
// DONE    | result ready, stall released, {HI,LO} written at end of cycle
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic              stall_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              div0_o
);
   hilo_state_e         state;
   logic [2:0]          mul_cnt;
   logic                mul_q;
   logic                div0_q;
   logic                start_ok, accept_mul, accept_div;
   logic                sx_a, sx_b;
   logic [2*DATA_W-1:0] ext_a, ext_b, product;
   logic [2*DATA_W-1:0] mul_pipe [MUL_STAGES];
   logic [DATA_W-1:0]   div_q, div_r;
   logic                div_done;

   assign start_ok   = !rst && !flush && (state == ST_IDLE) && start_i;
   assign accept_mul = start_ok && is_mul_op(op_i);
   assign accept_div = start_ok && is_div_op(op_i);
   assign stall_o    = !rst && !flush &&
                       (accept_mul || accept_div || state == ST_MUL || state == ST_DIV);

   // Sign-extending to 2*DATA_W makes the low half of one multiplier exact for both signednesses.
   assign sx_a    = (op_i == HILO_OP_MULT) && src_a[DATA_W-1];
   assign sx_b    = (op_i == HILO_OP_MULT) && src_b[DATA_W-1];
   assign ext_a   = {{DATA_W{sx_a}}, src_a};
   assign ext_b   = {{DATA_W{sx_b}}, src_b};
   assign product = ext_a * ext_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
      end else begin
         if (accept_mul) mul_pipe[0] <= product;
         for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   hilo_muldiv_unit_div_radix2 #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept_div),
      .abort     (flush),
      .signed_en (op_i == HILO_OP_DIV),
      .dividend  (src_a),
      .divisor   (src_b),
      .quotient  (div_q),
      .remainder (div_r),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         hi_o    <= '0;
         lo_o    <= '0;
         div0_o  <= 1'b0;
         mul_cnt <= '0;
         mul_q   <= 1'b0;
         div0_q  <= 1'b0;
      end else if (flush) begin
         state   <= ST_IDLE;
         div0_o  <= 1'b0;
         mul_cnt <= '0;
      end else begin
         div0_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  case (op_i)
                     HILO_OP_MTHI: hi_o <= src_a;
                     HILO_OP_MTLO: lo_o <= src_a;
                     HILO_OP_MULT, HILO_OP_MULTU: begin
                        mul_q   <= 1'b1;
                        mul_cnt <= 3'(MUL_STAGES - 1);
                        state   <= (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
                     end
                     HILO_OP_DIV, HILO_OP_DIVU: begin
                        mul_q  <= 1'b0;
                        div0_q <= (src_b == '0);
                        state  <= ST_DIV;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (mul_cnt == 3'd1) begin
                  state   <= ST_DONE;
                  mul_cnt <= '0;
               end else begin
                  mul_cnt <= mul_cnt - 3'd1;
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  state  <= ST_DONE;
                  div0_o <= div0_q;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (mul_q) begin
                  {hi_o, lo_o} <= mul_pipe[MUL_STAGES-1];
               end else begin
                  hi_o <= div_r;
                  lo_o <= div_q;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: four instances (MUL_STAGES 1..4) checked against
// a plain-arithmetic HI/LO model every cycle, plus hand-computed literals.
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   localparam int W = 32;
   localparam int MAIN = 1;

   logic         clk = 1'b0;
   logic         rst, flush;
   logic [3:0]   start_s;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic [3:0]   stall, div0;
   logic [W-1:0] hi [4];
   logic [W-1:0] lo [4];

   logic [W-1:0] exp_hi [4];
   logic [W-1:0] exp_lo [4];
   bit           cmp_en = 1'b0;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      hilo_muldiv_unit #(.DATA_W(W), .MUL_STAGES(k + 1)) u_dut (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .start_i (start_s[k]),
         .op_i    (op),
         .src_a   (a),
         .src_b   (b),
         .stall_o (stall[k]),
         .hi_o    (hi[k]),
         .lo_o    (lo[k]),
         .div0_o  (div0[k])
      );
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   // Architectural result of a mul/div op as {HI, LO}.
   function automatic logic [63:0] model_muldiv(input logic [2:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
      longint          sx, sy;
      longint unsigned ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = 64'(x);
      uy = 64'(y);
      case (o)
         HILO_OP_MULT:  return 64'(sx * sy);
         HILO_OP_MULTU: return ux * uy;
         HILO_OP_DIV:   return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
         HILO_OP_DIVU:  return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
         default:       return 64'd0;
      endcase
   endfunction

   function automatic int exp_stall(input logic [2:0] o, input int k);
      if (is_mul_op(o)) return k + 1;
      if (is_div_op(o)) return W + 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("hi_track%0d", k), 64'(hi[k]), 64'(exp_hi[k]));
            check($sformatf("lo_track%0d", k), 64'(lo[k]), 64'(exp_lo[k]));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the write edge.
   task automatic run_op(input int k, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input string name);
      int n, pulses;
      bit done_seen;
      n = 0; pulses = 0; done_seen = 1'b0;
      start_s[k] = 1'b1; op = o; a = x; b = y;
      for (int c = 0; c < W + 20; c++) begin
         @(negedge clk);
         if (div0[k]) pulses++;
         if (!stall[k]) begin
            done_seen = 1'b1;
            break;
         end
         n++;
      end
      check({name, "_done"}, 64'(done_seen), 64'd1);
      check({name, "_stall"}, 64'(n), 64'(exp_stall(o, k)));
      check({name, "_div0"}, 64'(pulses), 64'((is_div_op(o) && y == 0) ? 1 : 0));
      @(posedge clk); #1;
      start_s[k] = 1'b0;
      case (o)
         HILO_OP_MTHI: exp_hi[k] = x;
         HILO_OP_MTLO: exp_lo[k] = x;
         HILO_OP_MULT, HILO_OP_MULTU, HILO_OP_DIV, HILO_OP_DIVU:
            {exp_hi[k], exp_lo[k]} = model_muldiv(o, x, y);
         default: ;
      endcase
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; start_s = '0; op = '0; a = '0; b = '0;
      for (int k = 0; k < 4; k++) begin exp_hi[k] = '0; exp_lo[k] = '0; end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_hi", 64'(hi[MAIN]), 64'd0);
      check("reset_lo", 64'(lo[MAIN]), 64'd0);
      check("reset_stall", 64'(stall), 64'd0);
      check("reset_div0", 64'(div0), 64'd0);
      cmp_en = 1'b1;
      @(posedge clk); #1;

      run_op(MAIN, HILO_OP_MULT, -32'sd3, 32'd7, "mult_m3x7");
      check("mult_m3x7_lit", {hi[MAIN], lo[MAIN]}, 64'hFFFFFFFF_FFFFFFEB);
      run_op(MAIN, HILO_OP_DIV, -32'sd7, 32'd2, "div_m7d2");
      check("div_m7d2_lit", {hi[MAIN], lo[MAIN]}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(MAIN, HILO_OP_DIVU, -32'sd7, 32'd2, "divu_m7d2");
      check("divu_m7d2_lit", {hi[MAIN], lo[MAIN]}, 64'h00000001_7FFFFFFC);
      run_op(MAIN, HILO_OP_DIVU, 32'd5, 32'd0, "divu_by0");
      check("divu_by0_lit", {hi[MAIN], lo[MAIN]}, 64'h00000005_FFFFFFFF);
      run_op(MAIN, HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
      check("div_min_m1_lit", {hi[MAIN], lo[MAIN]}, 64'h00000000_80000000);
      run_op(MAIN, HILO_OP_MTHI, 32'h1234, 32'd0, "mthi");
      run_op(MAIN, HILO_OP_MTLO, 32'h5678, 32'd0, "mtlo");
      check("mthi_mtlo_lit", {hi[MAIN], lo[MAIN]}, 64'h00001234_00005678);
      run_op(MAIN, HILO_OP_MULTU, 32'd0, 32'd0, "multu_zero");
      check("multu_zero_lit", {hi[MAIN], lo[MAIN]}, 64'd0);

      run_op(MAIN, HILO_OP_DIV, 32'd100, -32'sd7, "div_100_m7");
      check("div_100_m7_lit", {hi[MAIN], lo[MAIN]}, 64'h00000002_FFFFFFF2);
      run_op(MAIN, HILO_OP_DIV, -32'sd100, 32'd0, "div_signed_by0");
      run_op(MAIN, HILO_OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
      run_op(MAIN, HILO_OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "mult_max_m1");
      run_op(MAIN, HILO_OP_DIVU, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
      run_op(MAIN, HILO_OP_DIVU, 32'h1234_5678, 32'h0000_FFFF, "divu_mixed");
      run_op(MAIN, HILO_OP_NONE, 32'hAAAA_AAAA, 32'd3, "op_none");
      run_op(MAIN, 3'd7, 32'h5555_5555, 32'd3, "op_undef");

      // Flush in the tenth cycle after a DIV is accepted.
      start_s[MAIN] = 1'b1; op = HILO_OP_DIV; a = 32'd1000; b = 32'd3;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("flush_pre_stall", 64'(stall[MAIN]), 64'd1);
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_stall", 64'(stall[MAIN]), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; start_s[MAIN] = 1'b0;
      run_op(MAIN, HILO_OP_MULTU, 32'd3, 32'd5, "after_flush");

      // Flush while IDLE suppresses an MTHI write.
      start_s[MAIN] = 1'b1; op = HILO_OP_MTHI; a = 32'hDEAD_BEEF; flush = 1'b1;
      @(negedge clk);
      check("flush_idle_stall", 64'(stall[MAIN]), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; start_s[MAIN] = 1'b0;
      @(negedge clk);
      check("flush_idle_hi", 64'(hi[MAIN]), 64'(exp_hi[MAIN]));
      @(posedge clk); #1;

      // Reset in the tenth cycle of a DIV.
      start_s[MAIN] = 1'b1; op = HILO_OP_DIV; a = -32'sd50; b = 32'd7;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_stall", 64'(stall[MAIN]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; start_s[MAIN] = 1'b0;
      for (int k = 0; k < 4; k++) begin exp_hi[k] = '0; exp_lo[k] = '0; end
      @(negedge clk);
      check("rst_hilo", {hi[MAIN], lo[MAIN]}, 64'd0);
      check("rst_stall_after", 64'(stall[MAIN]), 64'd0);
      check("rst_div0", 64'(div0[MAIN]), 64'd0);
      @(posedge clk); #1;
      run_op(MAIN, HILO_OP_DIV, -32'sd50, 32'd7, "after_rst");

      for (int k = 0; k < 4; k++) begin
         run_op(k, HILO_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("sweep%0d", k + 1));
         check($sformatf("sweep%0d_lit", k + 1), {hi[k], lo[k]}, 64'hFFFFFFFE_00000001);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
